// File: rtl/reflet_word_to_byte_bridge_pkg.sv
// Shared definitions for the word-to-byte bridge: FSM state encoding and the
// bytes-per-word helper.
package reflet_word_to_byte_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int bytes_per_word(input int word_size);
    return word_size / 8;
  endfunction

endpackage

// File: rtl/reflet_word_to_byte_bridge_if.sv
// Upstream word-access bus: the requester drives master, the bridge is slave.
interface reflet_word_to_byte_bridge_if #(
  parameter int word_size = 32,
  parameter int addr_size = 32
) ();

  logic [addr_size-1:0] up_addr;
  logic [word_size-1:0] up_data_in;
  logic [word_size-1:0] up_data_out;
  logic                 up_read_en;
  logic                 up_write_en;
  logic                 up_ready;

  modport master (
    output up_addr, up_data_in, up_read_en, up_write_en,
    input  up_data_out, up_ready
  );

  modport slave (
    input  up_addr, up_data_in, up_read_en, up_write_en,
    output up_data_out, up_ready
  );

endinterface

// File: rtl/reflet_word_to_byte_bridge.sv
// Splits one upstream word access into word_size/8 little-endian byte
// accesses on a byte-wide memory with one-cycle read latency.
module reflet_word_to_byte_bridge
  import reflet_word_to_byte_bridge_pkg::*;
#(
  parameter int word_size = 32,
  parameter int addr_size = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  reflet_word_to_byte_bridge_if.slave up,
  output logic [addr_size-1:0] mem_addr,
  output logic [7:0]           mem_data_out,
  input  logic [7:0]           mem_data_in,
  output logic                 mem_write_en
);

  localparam int n_bytes = bytes_per_word(word_size);
  localparam int idx_w   = $clog2(n_bytes);
  localparam int buf_w   = word_size - 8;
  localparam logic [idx_w-1:0]     last_idx = idx_w'(n_bytes - 1);
  localparam logic [addr_size-1:0] low_mask = addr_size'(n_bytes - 1);

  state_t               state;
  logic [idx_w-1:0]     i;
  logic [idx_w-1:0]     i_next;
  logic [addr_size-1:0] base;
  logic [addr_size-1:0] addr_next;
  logic [addr_size-1:0] up_base;
  // Bytes 1..N-1 still to be written, shifted down one byte per strobe.
  logic [buf_w-1:0]     wbuf;
  // Bytes 0..N-2 of the word being read, shifted in from the top.
  logic [buf_w-1:0]     rbuf;

  assign i_next    = i + 1'b1;
  assign addr_next = base + addr_size'(i_next);
  assign up_base   = up.up_addr & ~low_mask;

  // NOTE: the data holding registers are reset along with the control state so
  // every output is a known 0 while reset is low, not just the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      i              <= '0;
      base           <= '0;
      wbuf           <= '0;
      rbuf           <= '0;
      mem_addr       <= '0;
      mem_data_out   <= '0;
      mem_write_en   <= 1'b0;
      up.up_ready    <= 1'b0;
      up.up_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (up.up_write_en) begin
            base         <= up_base;
            mem_addr     <= up_base;
            mem_data_out <= up.up_data_in[7:0];
            wbuf         <= up.up_data_in[word_size-1:8];
            mem_write_en <= 1'b1;
            i            <= '0;
            state        <= WRITE;
          end else if (up.up_read_en) begin
            base     <= up_base;
            mem_addr <= up_base;
            i        <= '0;
            state    <= READ;
          end
        end

        WRITE: begin
          if (i == last_idx) begin
            mem_write_en <= 1'b0;
            mem_data_out <= '0;
            up.up_ready  <= 1'b1;
            i            <= '0;
            state        <= DONE;
          end else begin
            i            <= i_next;
            mem_addr     <= addr_next;
            mem_data_out <= wbuf[7:0];
            wbuf         <= wbuf >> 8;
          end
        end

        READ: begin
          // The byte addressed in the previous READ cycle is on mem_data_in now.
          if (i != '0) rbuf <= buf_w'({mem_data_in, rbuf} >> 8);
          if (i == last_idx) begin
            i     <= '0;
            state <= DRAIN;
          end else begin
            i        <= i_next;
            mem_addr <= addr_next;
          end
        end

        DRAIN: begin
          up.up_data_out <= {mem_data_in, rbuf};
          up.up_ready    <= 1'b1;
          state          <= DONE;
        end

        DONE: begin
          up.up_ready <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
